// File: rtl/calc_keypad_pkg.sv
// calc_keypad_pkg: shared types and constants for the calculator keypad scanner.
//   - scan_state_e : debounce/report FSM states (IDLE, CAND, HELD, REL)
//   - KEY_ROWS / KEY_COLS : matrix geometry; key code = row*KEY_COLS + col
//   - KEY_* : key codes for the calculator legend printed on the keypad
//   - eval_snapshot() : classifies a full-matrix snapshot as none/single/chord
//     and returns the index of the pressed key
package calc_keypad_pkg;

    localparam int KEY_ROWS  = 4;
    localparam int KEY_COLS  = 4;
    localparam int KEY_COUNT = KEY_ROWS * KEY_COLS;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAND,
        ST_HELD,
        ST_REL
    } scan_state_e;

    typedef enum logic [1:0] {
        SNAP_NONE,
        SNAP_SINGLE,
        SNAP_CHORD
    } snap_kind_e;

    typedef struct packed {
        snap_kind_e kind;
        logic [3:0] index;
    } snap_eval_t;

    // Legend, row by row:  1 2 3 +  /  4 5 6 -  /  7 8 9 *  /  C 0 = /
    localparam logic [3:0] KEY_D1    = 4'd0;
    localparam logic [3:0] KEY_D2    = 4'd1;
    localparam logic [3:0] KEY_D3    = 4'd2;
    localparam logic [3:0] KEY_ADD   = 4'd3;
    localparam logic [3:0] KEY_D4    = 4'd4;
    localparam logic [3:0] KEY_D5    = 4'd5;
    localparam logic [3:0] KEY_D6    = 4'd6;
    localparam logic [3:0] KEY_SUB   = 4'd7;
    localparam logic [3:0] KEY_D7    = 4'd8;
    localparam logic [3:0] KEY_D8    = 4'd9;
    localparam logic [3:0] KEY_D9    = 4'd10;
    localparam logic [3:0] KEY_MUL   = 4'd11;
    localparam logic [3:0] KEY_CLEAR = 4'd12;
    localparam logic [3:0] KEY_D0    = 4'd13;
    localparam logic [3:0] KEY_EQ    = 4'd14;
    localparam logic [3:0] KEY_DIV   = 4'd15;

    // The returned index is only meaningful when kind is SNAP_SINGLE.
    function automatic snap_eval_t eval_snapshot(input logic [KEY_COUNT-1:0] snap);
        snap_eval_t res;
        int         hits;
        res.kind  = SNAP_NONE;
        res.index = '0;
        hits      = 0;
        for (int i = 0; i < KEY_COUNT; i++) begin
            if (snap[i]) begin
                hits++;
                res.index = 4'(i);
            end
        end
        if (hits == 1) begin
            res.kind = SNAP_SINGLE;
        end else if (hits > 1) begin
            res.kind = SNAP_CHORD;
        end
        return res;
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// keypad_sync: WIDTH-bit two-flop synchronizer for asynchronous inputs.
// Ports:
//   clock    in   system clock
//   reset_n  in   asynchronous active-low reset (flops load RESET_VALUE)
//   d        in   asynchronous input bus
//   q        out  synchronized bus, two clocks of latency
module keypad_sync #(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= RESET_VALUE;
            sync_q <= RESET_VALUE;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: scans a 4x4 active-low key matrix one column per slot,
// debounces whole-matrix scans, rejects chords and reports each press as a
// 4-bit key code through a single valid/ready holding register.
// Ports:
//   clock      in   system clock
//   reset_n    in   asynchronous active-low reset
//   col_n      out  column drive, exactly one bit low
//   row_n      in   row sense, active-low, asynchronous
//   key_code   out  reported key, row*4 + col
//   key_valid  out  key_code valid, held until accepted
//   key_ready  in   consumer accepts when key_valid && key_ready
//   overflow   out  sticky, set when a report finds the holding register busy
// Optional feature: define KEYPAD_REPEAT_EN to auto-repeat a held key after
// REPEAT_DELAY_SCANS scans and then every REPEAT_RATE_SCANS scans.
module keypad_scan
    import calc_keypad_pkg::*;
#(
    parameter int DIV_BITS           = 13,
    parameter int DEBOUNCE_SCANS     = 16,
    parameter int REPEAT_DELAY_SCANS = 64,
    parameter int REPEAT_RATE_SCANS  = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    output logic [3:0] col_n,
    input  logic [3:0] row_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       overflow
);

    localparam int                  STABLE_W      = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [STABLE_W-1:0] STABLE_TARGET = STABLE_W'(DEBOUNCE_SCANS);
    localparam logic [STABLE_W-1:0] STABLE_ONE    = STABLE_W'(1);

    if (DIV_BITS < 2 || DEBOUNCE_SCANS < 1 || REPEAT_DELAY_SCANS < 1 || REPEAT_RATE_SCANS < 1)
    begin : g_param_check
        $error("keypad_scan: parameter below its minimum");
    end

    logic [3:0]          row_s;
    logic [DIV_BITS-1:0] slot_cnt_q, slot_cnt_d;
    logic [1:0]          col_q, col_d;
    logic [3:0]          col_n_q, col_n_d;
    logic [15:0]         snap_q, snap_d;
    scan_state_e         state_q, state_d;
    logic [3:0]          key_q, key_d;
    logic [STABLE_W-1:0] stable_q, stable_d, stable_inc;
    logic [3:0]          code_q, code_d;
    logic                valid_q, valid_d;
    logic                ovf_q, ovf_d;
    logic                slot_end, scan_end, report, same_key;
    snap_eval_t          eval;

    keypad_sync #(.WIDTH(4), .RESET_VALUE(4'hF)) u_row_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (row_n),
        .q       (row_s)
    );

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY_SCANS > REPEAT_RATE_SCANS) ?
                             REPEAT_DELAY_SCANS : REPEAT_RATE_SCANS;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d, rep_inc;
    logic [REP_W-1:0] rep_target_q, rep_target_d;
`endif

    // Column slots and snapshot. The column being sampled is overwritten in
    // snap_d on its last slot cycle, so at scan end snap_d is the complete
    // matrix for that scan.
    always_comb begin
        slot_end   = &slot_cnt_q;
        scan_end   = slot_end && (col_q == 2'd3);
        slot_cnt_d = slot_cnt_q + 1'b1;
        col_d      = slot_end ? col_q + 2'd1 : col_q;
        col_n_d    = slot_end ? {col_n_q[2:0], col_n_q[3]} : col_n_q;
        snap_d     = snap_q;
        if (slot_end) begin
            for (int r = 0; r < KEY_ROWS; r++) begin
                snap_d[r*KEY_COLS + int'(col_q)] = ~row_s[r];
            end
        end
        eval = eval_snapshot(snap_d);
    end

    // Debounce FSM, evaluated once per scan end.
    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        stable_d   = stable_q;
        report     = 1'b0;
        same_key   = (eval.kind == SNAP_SINGLE) && (eval.index == key_q);
        stable_inc = (stable_q == STABLE_TARGET) ? stable_q : stable_q + 1'b1;
`ifdef KEYPAD_REPEAT_EN
        rep_cnt_d    = rep_cnt_q;
        rep_target_d = rep_target_q;
        rep_inc      = (&rep_cnt_q) ? rep_cnt_q : rep_cnt_q + 1'b1;
`endif
        if (scan_end) begin
            case (state_q)
                ST_IDLE: begin
                    if (eval.kind == SNAP_SINGLE) begin
                        key_d    = eval.index;
                        stable_d = STABLE_ONE;
                        if (STABLE_ONE == STABLE_TARGET) begin
                            report  = 1'b1;
                            state_d = ST_HELD;
                        end else begin
                            state_d = ST_CAND;
                        end
                    end
                end
                ST_CAND: begin
                    if (same_key) begin
                        stable_d = stable_inc;
                        if (stable_inc == STABLE_TARGET) begin
                            report  = 1'b1;
                            state_d = ST_HELD;
                        end
                    end else begin
                        state_d  = ST_IDLE;
                        stable_d = '0;
                    end
                end
                ST_HELD: begin
                    if (same_key || eval.kind == SNAP_CHORD) begin
`ifdef KEYPAD_REPEAT_EN
                        if (rep_inc == rep_target_q) begin
                            report       = 1'b1;
                            rep_cnt_d    = '0;
                            rep_target_d = REP_W'(REPEAT_RATE_SCANS);
                        end else begin
                            rep_cnt_d = rep_inc;
                        end
`endif
                    end else if (STABLE_ONE == STABLE_TARGET) begin
                        state_d  = ST_IDLE;
                        stable_d = '0;
                    end else begin
                        state_d  = ST_REL;
                        stable_d = STABLE_ONE;
                    end
                end
                ST_REL: begin
                    if (eval.kind == SNAP_NONE) begin
                        stable_d = stable_inc;
                        if (stable_inc == STABLE_TARGET) begin
                            state_d  = ST_IDLE;
                            stable_d = '0;
                        end
                    end else if (same_key || eval.kind == SNAP_CHORD) begin
                        state_d = ST_HELD;
                    end else begin
                        state_d  = ST_IDLE;
                        stable_d = '0;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    stable_d = '0;
                end
            endcase
        end
`ifdef KEYPAD_REPEAT_EN
        // A fresh press restarts the repeat schedule from the initial delay.
        if (report && state_q != ST_HELD) begin
            rep_cnt_d    = '0;
            rep_target_d = REP_W'(REPEAT_DELAY_SCANS);
        end
        if (state_d == ST_IDLE) begin
            rep_cnt_d = '0;
        end
`endif
    end

    // Holding register: a report arriving while the old code is still
    // unaccepted is dropped and flagged, unless the old one leaves this cycle.
    always_comb begin
        code_d  = code_q;
        valid_d = (valid_q && key_ready) ? 1'b0 : valid_q;
        ovf_d   = ovf_q;
        if (report) begin
            if (!valid_q || key_ready) begin
                code_d  = key_d;
                valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            slot_cnt_q <= '0;
            col_q      <= 2'd0;
            col_n_q    <= 4'b1110;
            snap_q     <= '0;
            state_q    <= ST_IDLE;
            key_q      <= '0;
            stable_q   <= '0;
            code_q     <= '0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            slot_cnt_q <= slot_cnt_d;
            col_q      <= col_d;
            col_n_q    <= col_n_d;
            snap_q     <= snap_d;
            state_q    <= state_d;
            key_q      <= key_d;
            stable_q   <= stable_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rep_cnt_q    <= '0;
            rep_target_q <= '0;
        end else begin
            rep_cnt_q    <= rep_cnt_d;
            rep_target_q <= rep_target_d;
        end
    end
`endif

    assign col_n     = col_n_q;
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: bench for keypad_scan with a 16-cycle scan (DIV_BITS=2)
// and 3-scan debounce. A behavioural key matrix drives row_n from col_n; a
// scan-level reference model predicts col_n, key_valid, key_code and overflow
// every cycle. Key changes are applied at scan boundaries.
module tb_keypad_scan;

    localparam int DIV_BITS = 2;
    localparam int DEB      = 3;
    localparam int SLOT     = 1 << DIV_BITS;
    localparam int SCAN     = 4 * SLOT;

    localparam int M_IDLE = 0;
    localparam int M_CAND = 1;
    localparam int M_HELD = 2;
    localparam int M_REL  = 3;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [3:0]  col_n;
    logic [3:0]  row_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ready;
    logic        overflow;
    logic [15:0] pressed;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int held_key = 6;

    int         m_mode;
    int         m_key;
    int         m_count;
    logic [3:0] m_code;
    logic       m_valid;
    logic       m_ovf;

    keypad_scan #(
        .DIV_BITS       (DIV_BITS),
        .DEBOUNCE_SCANS (DEB)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .col_n     (col_n),
        .row_n     (row_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .overflow  (overflow)
    );

    always #5 clock = ~clock;

    // A pressed key shorts its row to its column whenever that column is low.
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!col_n[c] && pressed[r*4 + c]) row_n[r] = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic checkOutput();
        logic [3:0] exp_col;
        exp_col = 4'hF;
        exp_col[(cyc / SLOT) % 4] = 1'b0;
        check("col_n", col_n, exp_col);
        check("key_valid", {3'b0, key_valid}, {3'b0, m_valid});
        check("key_code", key_code, m_code);
        check("overflow", {3'b0, overflow}, {3'b0, m_ovf});
    endtask

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_key   = 0;
        m_count = 0;
        m_code  = 4'd0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
    endtask

    // One scan's worth of the press/release rules; rep is set when the scan
    // produces a report of m_key.
    task automatic model_scan(input logic [15:0] keys, output bit rep);
        int n;
        int k;
        n   = $countones(keys);
        k   = -1;
        rep = 0;
        for (int i = 0; i < 16; i++) if (keys[i]) k = i;
        case (m_mode)
            M_IDLE: if (n == 1) begin
                m_mode = M_CAND; m_key = k; m_count = 1;
            end
            M_CAND: if (n == 1 && k == m_key) begin
                m_count++;
                if (m_count >= DEB) begin rep = 1; m_mode = M_HELD; end
            end else begin
                m_mode = M_IDLE;
            end
            M_HELD: if (!(n > 1 || (n == 1 && k == m_key))) begin
                m_mode = M_REL; m_count = 1;
            end
            default: if (n == 0) begin
                m_count++;
                if (m_count >= DEB) m_mode = M_IDLE;
            end else if (n > 1 || k == m_key) begin
                m_mode = M_HELD;
            end else begin
                m_mode = M_IDLE;
            end
        endcase
    endtask

    task automatic tick();
        bit rep;
        rep = 0;
        if ((cyc % SCAN) == SCAN - 1) model_scan(pressed, rep);
        if (rep) begin
            if (!m_valid || key_ready) begin
                m_code  = 4'(m_key);
                m_valid = 1'b1;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (m_valid && key_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clock);
        #1;
        cyc++;
        checkOutput();
    endtask

    // ready_mode: 0 low, 1 high, 2 random, 3 high on the first cycle only.
    task automatic applyStimulus(input logic [15:0] keys, input int ready_mode);
        pressed = keys;
        for (int i = 0; i < SCAN; i++) begin
            case (ready_mode)
                0:       key_ready = 1'b0;
                1:       key_ready = 1'b1;
                2:       key_ready = 1'($urandom_range(0, 1));
                default: key_ready = (i == 0);
            endcase
            tick();
        end
    endtask

    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_col_n", col_n, 4'b1110);
        check("rst_key_valid", {3'b0, key_valid}, 4'd0);
        check("rst_key_code", key_code, 4'd0);
        check("rst_overflow", {3'b0, overflow}, 4'd0);
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        cyc = 0;
    endtask

    initial begin
        logic [15:0] keys;
        reset_n   = 1'b1;
        pressed   = '0;
        key_ready = 1'b0;
        model_reset();
        do_reset();

        $display("[TB] idle column scan");
        for (int s = 0; s < 2; s++) applyStimulus(16'h0000, 1);

        $display("[TB] key 6 press, release, press");
        for (int s = 0; s < 6; s++) applyStimulus(16'h0040, 1);
        for (int s = 0; s < 4; s++) applyStimulus(16'h0000, 1);
        for (int s = 0; s < 6; s++) applyStimulus(16'h0040, 1);
        for (int s = 0; s < 4; s++) applyStimulus(16'h0000, 1);

        $display("[TB] bouncing key 6");
        for (int s = 0; s < 10; s++) applyStimulus((s % 2 == 0) ? 16'h0040 : 16'h0000, 1);
        for (int s = 0; s < 3; s++) applyStimulus(16'h0000, 1);

        $display("[TB] chord 0+5 then 5 alone");
        for (int s = 0; s < 5; s++) applyStimulus(16'h0021, 1);
        for (int s = 0; s < 4; s++) applyStimulus(16'h0020, 1);
        for (int s = 0; s < 4; s++) applyStimulus(16'h0000, 1);

        $display("[TB] overflow with consumer stalled");
        for (int s = 0; s < 4; s++) applyStimulus(16'h0040, 0);
        for (int s = 0; s < 4; s++) applyStimulus(16'h0000, 0);
        for (int s = 0; s < 4; s++) applyStimulus(16'h0200, 0);
        check("held_code_6", key_code, 4'd6);
        check("overflow_set", {3'b0, overflow}, 4'd1);
        applyStimulus(16'h0000, 3);
        check("overflow_sticky", {3'b0, overflow}, 4'd1);

        $display("[TB] reset during candidate and during held");
        for (int s = 0; s < 2; s++) applyStimulus(16'h0040, 1);
        for (int i = 0; i < 5; i++) tick();
        do_reset();
        for (int s = 0; s < 4; s++) applyStimulus(16'h0040, 0);
        check("valid_before_reset", {3'b0, key_valid}, 4'd1);
        for (int i = 0; i < 7; i++) tick();
        do_reset();
        for (int s = 0; s < 4; s++) applyStimulus(16'h0040, 1);
        for (int s = 0; s < 4; s++) applyStimulus(16'h0000, 1);

        $display("[TB] random key activity");
        for (int s = 0; s < 80; s++) begin
            case ($urandom_range(0, 7))
                0, 1:    keys = 16'h0000;
                2, 3, 4: keys = 16'h0001 << held_key;
                5: begin
                    held_key = int'($urandom_range(0, 15));
                    keys = 16'h0001 << held_key;
                end
                6:       keys = (16'h0001 << held_key) | (16'h0001 << $urandom_range(0, 15));
                default: keys = 16'($urandom);
            endcase
            applyStimulus(keys, 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
